jk_bank_arbiter: RTL
====================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (range 2..8).
REQ-002 Parameter ADDR_W, default 3, SHALL set the cell address width; N_CELL = 2**ADDR_W JK cells.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  SHALL be the asynchronous active-low reset.
REQ-005 ENABLE  input  1  SHALL permit new grants when 1; an in-flight transaction completes regardless.
REQ-006 REQ  input  N_REQ  SHALL carry the per-requester request level, bit i = requester i.
REQ-007 OP  input  2*N_REQ  SHALL carry the per-requester op, OP[2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-008 ADDR  input  ADDR_W*N_REQ  SHALL carry the per-requester cell index, ADDR[ADDR_W*i +: ADDR_W].
REQ-009 GNT  output  N_REQ  SHALL be the registered one-hot grant, all-zero when no transaction is active.
REQ-010 J_8  output  N_CELL  SHALL be the decoded one-hot J strobe, all-zero outside APPLY.
REQ-011 K_8  output  N_CELL  SHALL be the decoded one-hot K strobe, all-zero outside APPLY.
REQ-012 Q_8  output  N_CELL  SHALL be the registered JK cell bank state.
REQ-013 BUSY  output  1  SHALL be 1 whenever state is not IDLE.
REQ-014 DONE  output  1  SHALL be 1 for exactly the ACK cycle.

Function
REQ-015 FSM states SHALL be IDLE, APPLY, ACK; the FSM SHALL traverse IDLE->APPLY->ACK->IDLE, with no other transitions.
REQ-016 IDLE: if ENABLE=1 and REQ!=0, the FSM SHALL select a winner, latch its OP/ADDR, set GNT to the winner's one-hot and enter APPLY at the next edge; otherwise it SHALL stay in IDLE with GNT=0.
REQ-017 Winner selection SHALL be round-robin: search REQ upward from pointer PTR, modulo N_REQ; the first set bit wins.
REQ-018 PTR SHALL update to (winner+1) mod N_REQ on the ACK->IDLE edge only.
REQ-019 APPLY: J_8 and K_8 SHALL be driven from the latched op and address: 01 K one-hot; 10 J one-hot; 11 J and K one-hot; 00 both zero.
REQ-020 APPLY->ACK edge: each Q_8 bit SHALL update per the JK rule (00 hold, 01 clear, 10 set, 11 invert); unaddressed bits SHALL hold.
REQ-021 ACK: DONE=1 and GNT SHALL remain asserted; the FSM SHALL enter IDLE unconditionally at the next edge.
REQ-022 Latency SHALL be 2 edges from the sampled REQ to the Q_8 update; throughput SHALL be one transaction per 3 cycles.
REQ-023 REQ, OP and ADDR changes during APPLY/ACK SHALL NOT affect the in-flight transaction.
REQ-024 A REQ still high in IDLE after its ACK SHALL be treated as a new request, subject to rotation.
REQ-025 A deasserted REQ SHALL never be granted.
REQ-026 ENABLE falling in APPLY or ACK SHALL NOT abort the transaction.
REQ-027 An OP=00 transaction SHALL complete the full handshake, including GNT and DONE, with Q_8 unchanged.
REQ-028 A toggle of a cell SHALL invert its current value, including a cell updated by the immediately preceding transaction.

Reset
REQ-029 RST_N=0 SHALL immediately force state=IDLE, PTR=0, GNT=0, Q_8=0, J_8=0, K_8=0, BUSY=0, DONE=0, independent of CLK.
REQ-030 Reset asserted mid-transaction SHALL discard it: no Q_8 update and no DONE.
REQ-031 After RST_N rises, the first grant SHALL be possible at the next posedge CLK.

Verification
REQ-032 Reset, then ENABLE=1, REQ=0001, OP0=10, ADDR0=3 -> edge1: GNT=0001, J_8=00001000; edge2: Q_8=00001000, DONE=1; edge3: IDLE, GNT=0.
REQ-033 REQ=1111 held, all OP=11, ADDRi=i -> grant order 0,1,2,3,0 at 3-cycle spacing; after 4 transactions Q_8=00001111, then bit0 returns to 0 on the 5th.
REQ-034 Requester 2 toggles cell 5 twice back-to-back -> Q_8[5] goes 1 then 0; DONE pulses twice, 3 cycles apart.
REQ-035 RST_N pulsed low during APPLY of a set of cell 6 -> Q_8=0 and GNT=0 immediately; no DONE; bank stays 0.
REQ-036 ENABLE=0 with REQ=0100 for 5 cycles -> BUSY=0, GNT=0 throughout; ENABLE=1 -> GNT=0100 at the next edge.
REQ-037 REQ=0010, OP1=00 -> GNT=0010 and DONE pulse occur; Q_8 unchanged; J_8=K_8=0 in APPLY.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// ---------------------------------------------------------------------------
// jk_bank_arbiter
//   Round-robin arbiter in front of a bank of JK flip-flop cells. One
//   requester at a time is granted. Its op and cell address are latched,
//   and the selected cell is held, cleared, set or toggled. Each
//   transaction walks IDLE -> APPLY -> ACK -> IDLE (three cycles).
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   ADDR_W  cell address width; the bank holds 2**ADDR_W cells
//
// Ports
//   clk     clock, rising-edge active
//   rst_n   asynchronous active-low reset
//   enable  permits new grants; an in-flight transaction always completes
//   req     per-requester request level
//   op      per-requester op, op[2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle
//   addr    per-requester cell index, addr[ADDR_W*i +: ADDR_W]
//   gnt     registered one-hot grant, held through APPLY and ACK
//   j_8     one-hot J strobe, active only in APPLY
//   k_8     one-hot K strobe, active only in APPLY
//   q_8     registered JK cell bank state
//   busy    high whenever the FSM is not in IDLE
//   done    high for the single ACK cycle
// ---------------------------------------------------------------------------
module jk_bank_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [ADDR_W*N_REQ-1:0]  addr,
  output logic [N_REQ-1:0]         gnt,
  output logic [2**ADDR_W-1:0]     j_8,
  output logic [2**ADDR_W-1:0]     k_8,
  output logic [2**ADDR_W-1:0]     q_8,
  output logic                     busy,
  output logic                     done
);

  localparam int N_CELL = 2**ADDR_W;
  localparam int PTR_W  = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;

  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [N_CELL-1:0] cell_onehot;

  // Round-robin search: start at ptr and wrap, so the requester served last
  // has the lowest priority on the next pass.
  // NOTE: every signal written in a combinational block is given a default
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Pick the winner's op and address out of the packed request buses.
  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_op   = op[2*i +: 2];
        sel_addr = addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Strobes come from the latched op and address only. Input changes during
  // APPLY and ACK therefore cannot disturb the transaction in flight.
  always_comb begin
    cell_onehot = N_CELL'(1) << addr_q;
    j_8         = '0;
    k_8         = '0;
    if (state == S_APPLY) begin
      if (op_q[1]) j_8 = cell_onehot;
      if (op_q[0]) k_8 = cell_onehot;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_ACK);

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the values from before the edge, whatever the
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      gnt    <= '0;
      win_q  <= '0;
      op_q   <= '0;
      addr_q <= '0;
      // NOTE: the cell bank is reset like ordinary flops. It is visible state
      // and must read zero straight after reset, so it is not treated as an
      // uninitialised memory.
      q_8    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && win_found) begin
            state  <= S_APPLY;
            gnt    <= N_REQ'(1) << win_idx;
            win_q  <= win_idx;
            op_q   <= sel_op;
            addr_q <= sel_addr;
          end else begin
            gnt <= '0;
          end
        end
        S_APPLY: begin
          state <= S_ACK;
          // JK next state: set where J is high, keep where K is low.
          // J=K=1 inverts. Cells with no strobe hold.
          q_8   <= (j_8 & ~q_8) | (~k_8 & q_8);
        end
        S_ACK: begin
          state <= S_IDLE;
          gnt   <= '0;
          ptr   <= (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
